// File: rtl/fabric_store_queue.sv
// -----------------------------------------------------------------------------
// fabric_store_queue
//
// Collects store addresses and store data from two independent streams. Each
// stream has its own FIFO. When both FIFOs hold an entry, one address and one
// data word are paired into a single memory write. The block then waits for
// the write acknowledge and emits one completion token. Only one write is in
// flight at any time.
//
// Parameters:
//   DATA_WIDTH  store data width (>= 1)
//   ADDR_WIDTH  store address width (>= 1)
//   DEPTH       entries per input FIFO (power of two, >= 2)
//
// Ports:
//   clk, rst                          clock; synchronous active-high reset
//   addr_valid/ready/data             store address stream (in)
//   wdata_valid/ready/data            store data stream (in)
//   mem_req_valid/ready/addr/data     memory write request (out)
//   mem_resp_valid/ready              memory write acknowledge (in)
//   done_valid/ready/data             completion token (out); data is always 0
//   busy                              high while a write is in flight or
//                                     either FIFO holds entries
//   store_count                       completed store count, 16-bit wrapping
//                                     (only with FABRIC_STORE_QUEUE_STATS_EN)
//
// Build option: define FABRIC_STORE_QUEUE_STATS_EN to add store_count.
// -----------------------------------------------------------------------------
module fabric_store_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  addr_valid,
  output logic                  addr_ready,
  input  logic [ADDR_WIDTH-1:0] addr_data,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic                  done_data,
  output logic                  busy
`ifdef FABRIC_STORE_QUEUE_STATS_EN
  ,
  output logic [15:0]           store_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] addr_wr_q, addr_rd_q;
  logic [PTR_W:0] wdata_wr_q, wdata_rd_q;

  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;

  logic addr_empty, addr_full, wdata_empty, wdata_full;
  logic addr_push, wdata_push, pop;

  assign addr_empty  = (addr_wr_q == addr_rd_q);
  assign addr_full   = (addr_wr_q[PTR_W] != addr_rd_q[PTR_W]) &&
                       (addr_wr_q[PTR_W-1:0] == addr_rd_q[PTR_W-1:0]);
  assign wdata_empty = (wdata_wr_q == wdata_rd_q);
  assign wdata_full  = (wdata_wr_q[PTR_W] != wdata_rd_q[PTR_W]) &&
                       (wdata_wr_q[PTR_W-1:0] == wdata_rd_q[PTR_W-1:0]);

  // Ready reflects occupancy at the start of the cycle only, so a pop in the
  // same cycle never opens a slot early and there is no ready->pop path.
  assign addr_ready  = !addr_full;
  assign wdata_ready = !wdata_full;
  assign addr_push   = addr_valid && addr_ready;
  assign wdata_push  = wdata_valid && wdata_ready;

  // Pairing happens only from IDLE, which also bounds in-flight writes to one.
  assign pop = (state_q == ST_IDLE) && !addr_empty && !wdata_empty;

  assign mem_req_addr = req_addr_q;
  assign mem_req_data = req_data_q;
  assign done_data    = 1'b0;
  assign busy         = (state_q != ST_IDLE) || !addr_empty || !wdata_empty;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    req_data_d     = req_data_q;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    done_valid     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          req_addr_d = addr_mem[addr_rd_q[PTR_W-1:0]];
          req_data_d = wdata_mem[wdata_rd_q[PTR_W-1:0]];
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries
  // are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (addr_push)  addr_mem[addr_wr_q[PTR_W-1:0]]   <= addr_data;
    if (wdata_push) wdata_mem[wdata_wr_q[PTR_W-1:0]] <= wdata_data;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_wr_q  <= '0;
      addr_rd_q  <= '0;
      wdata_wr_q <= '0;
      wdata_rd_q <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      if (addr_push)  addr_wr_q  <= addr_wr_q + PTR_ONE;
      if (wdata_push) wdata_wr_q <= wdata_wr_q + PTR_ONE;
      if (pop) begin
        addr_rd_q  <= addr_rd_q + PTR_ONE;
        wdata_rd_q <= wdata_rd_q + PTR_ONE;
      end
    end
  end

`ifdef FABRIC_STORE_QUEUE_STATS_EN
  logic [15:0] store_count_q;

  // Counts completed done handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_count_q <= '0;
    end else if (done_valid && done_ready) begin
      store_count_q <= store_count_q + 16'd1;
    end
  end

  assign store_count = store_count_q;
`endif

endmodule

// File: tb/tb_fabric_store_queue.sv
// -----------------------------------------------------------------------------
// tb_fabric_store_queue
//
// Self-checking bench for fabric_store_queue. A transaction-level reference
// model (two queues plus the write phase implied by the handshakes) predicts
// every output after each rising edge. Directed scenarios come first, then a
// randomized section.
// -----------------------------------------------------------------------------
module tb_fabric_store_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          addr_valid, addr_ready;
  logic [AW-1:0] addr_data;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata_data;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic          mem_resp_valid, mem_resp_ready;
  logic          done_valid, done_ready, done_data;
  logic          busy;
`ifdef FABRIC_STORE_QUEUE_STATS_EN
  logic [15:0]   store_count;
`endif

  always #5 clk = ~clk;

  fabric_store_queue #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr_valid    (addr_valid),
    .addr_ready    (addr_ready),
    .addr_data     (addr_data),
    .wdata_valid   (wdata_valid),
    .wdata_ready   (wdata_ready),
    .wdata_data    (wdata_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .done_valid    (done_valid),
    .done_ready    (done_ready),
    .done_data     (done_data),
    .busy          (busy)
`ifdef FABRIC_STORE_QUEUE_STATS_EN
    ,
    .store_count   (store_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model: what has been accepted but not yet paired, and where the
  // single in-flight write is in its handshake sequence.
  // ---------------------------------------------------------------------------
  typedef enum {P_NONE, P_REQ, P_RESP, P_DONE} phase_t;

  logic [AW-1:0] aq [$];
  logic [DW-1:0] dq [$];
  phase_t        ph;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  int unsigned   stores;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Applies the effect of one rising edge, using the inputs as driven.
  task automatic model_edge();
    bit acc_a, acc_d;
    if (rst) begin
      aq.delete();
      dq.delete();
      ph       = P_NONE;
      exp_addr = '0;
      exp_data = '0;
      stores   = 0;
    end else begin
      // Acceptance is judged on occupancy before this edge's pop.
      acc_a = addr_valid  && (aq.size() < DEPTH);
      acc_d = wdata_valid && (dq.size() < DEPTH);
      case (ph)
        P_NONE: if (aq.size() > 0 && dq.size() > 0) begin
          exp_addr = aq.pop_front();
          exp_data = dq.pop_front();
          ph       = P_REQ;
        end
        P_REQ:  if (mem_req_ready)  ph = P_RESP;
        P_RESP: if (mem_resp_valid) ph = P_DONE;
        P_DONE: if (done_ready) begin
          ph = P_NONE;
          stores++;
        end
        default: ph = P_NONE;
      endcase
      if (acc_a) aq.push_back(addr_data);
      if (acc_d) dq.push_back(wdata_data);
    end
  endtask

  task automatic check_outputs();
    check("addr_ready",     addr_ready,     aq.size() < DEPTH);
    check("wdata_ready",    wdata_ready,    dq.size() < DEPTH);
    check("mem_req_valid",  mem_req_valid,  ph == P_REQ);
    check("mem_resp_ready", mem_resp_ready, ph == P_RESP);
    check("done_valid",     done_valid,     ph == P_DONE);
    check("done_data",      done_data,      1'b0);
    check("busy",           busy,           (ph != P_NONE) || aq.size() > 0 || dq.size() > 0);
    check("mem_req_addr",   mem_req_addr,   exp_addr);
    check("mem_req_data",   mem_req_data,   exp_data);
`ifdef FABRIC_STORE_QUEUE_STATS_EN
    check("store_count",    store_count,    stores % 65536);
`endif
  endtask

  // One clock: DUT and model see the same inputs at the edge; outputs are
  // sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    addr_valid  = 1'b0;
    wdata_valid = 1'b0;
  endtask

  task automatic all_ready();
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    done_ready     = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    addr_valid     = 1'b0;
    addr_data      = '0;
    wdata_valid    = 1'b0;
    wdata_data     = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    done_ready     = 1'b0;
    ph             = P_NONE;
    exp_addr       = '0;
    exp_data       = '0;
    stores         = 0;

    // Reset state.
    tick();
    tick();
    check("rst_addr_ready",  addr_ready,    1'b1);
    check("rst_wdata_ready", wdata_ready,   1'b1);
    check("rst_busy",        busy,          1'b0);
    check("rst_req_addr",    mem_req_addr,  '0);
    rst = 1'b0;
    tick();

    // Single store, everything ready: request one cycle after both non-empty.
    all_ready();
    addr_valid  = 1'b1; addr_data  = 32'h0000_0100;
    wdata_valid = 1'b1; wdata_data = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    check("s1_no_req_yet", mem_req_valid, 1'b0);
    tick();
    check("s1_req_valid", mem_req_valid, 1'b1);
    check("s1_req_addr",  mem_req_addr,  32'h0000_0100);
    check("s1_req_data",  mem_req_data,  32'hDEAD_BEEF);
    tick();
    tick();
    check("s1_done_valid", done_valid, 1'b1);
    check("s1_done_data",  done_data,  1'b0);
    tick();
    check("s1_back_idle", busy, 1'b0);

    // Fill the address FIFO with no data; then a rejected fifth push.
    for (int i = 0; i < DEPTH; i++) begin
      addr_valid = 1'b1; addr_data = 32'h10 + i;
      tick();
    end
    check("fill_addr_ready", addr_ready,    1'b0);
    check("fill_no_req",     mem_req_valid, 1'b0);
    addr_data = 32'h0000_0BAD;
    tick();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      wdata_valid = 1'b1; wdata_data = 32'hA000_0000 + i;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 6 * DEPTH && busy; i++) tick();
    check("fill_drained", busy, 1'b0);

    // Request back-pressure: address/data must hold for 5 cycles.
    mem_req_ready = 1'b0;
    addr_valid  = 1'b1; addr_data  = 32'h0000_0200;
    wdata_valid = 1'b1; wdata_data = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    tick();
    repeat (5) begin
      tick();
      check("bp_req_valid", mem_req_valid, 1'b1);
      check("bp_req_addr",  mem_req_addr,  32'h0000_0200);
      check("bp_req_data",  mem_req_data,  32'hCAFE_F00D);
    end
    mem_req_ready = 1'b1;
    for (int i = 0; i < 10 && busy; i++) tick();

    // Slow response and slow done: second store must wait for done handshake.
    mem_resp_valid = 1'b0;
    done_ready     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      addr_valid  = 1'b1; addr_data  = 32'h300 + i;
      wdata_valid = 1'b1; wdata_data = 32'h5555_0000 + i;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 10 && ph != P_RESP; i++) tick();
    repeat (3) tick();
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    repeat (2) begin
      tick();
      check("slow_no_second_req", mem_req_valid, 1'b0);
    end
    done_ready = 1'b1;
    tick();
    check("slow_idle_no_req", mem_req_valid, 1'b0);
    all_ready();
    for (int i = 0; i < 12 && busy; i++) tick();

    // Reset while waiting for the response: transaction is abandoned.
    mem_resp_valid = 1'b0;
    addr_valid  = 1'b1; addr_data  = 32'h0000_0400;
    wdata_valid = 1'b1; wdata_data = 32'h1234_5678;
    tick();
    addr_data = 32'h0000_0404; wdata_data = 32'h8765_4321;
    tick();
    idle_inputs();
    tick();
    check("rr_in_resp", mem_resp_ready, 1'b1);
    rst = 1'b1;
    tick();
    check("rr_busy",   busy,        1'b0);
    check("rr_done",   done_valid,  1'b0);
    check("rr_aready", addr_ready,  1'b1);
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    repeat (3) begin
      tick();
      check("rr_no_token", done_valid, 1'b0);
    end

`ifdef FABRIC_STORE_QUEUE_STATS_EN
    // Three completed stores from a clean reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    all_ready();
    for (int i = 0; i < 3; i++) begin
      addr_valid  = 1'b1; addr_data  = 32'h500 + i;
      wdata_valid = 1'b1; wdata_data = 32'h7700 + i;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 20 && busy; i++) tick();
    check("stats_three", store_count, 16'd3);
`endif

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      addr_valid     = ($urandom_range(0, 1) == 1);
      addr_data      = $urandom;
      wdata_valid    = ($urandom_range(0, 2) != 0);
      wdata_data     = $urandom;
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_resp_valid = ($urandom_range(0, 2) != 0);
      done_ready     = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    all_ready();
    for (int i = 0; i < 6 * DEPTH + 8 && busy; i++) tick();
    check("final_drained", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
